// File: rtl/gameover_detect.sv
// gameover_detect: round timer, Tom/Jerry collision and game-over code/restart pulse (optional cheese win under GAMEOVER_CHEESE_EN)
module gameover_detect #(
  parameter int GAME_SECONDS = 60,
  parameter int FRAMES_PER_SEC = 60,
  parameter int HIT_DIST = 16,
  parameter int HIT_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [11:0] tom_x,
  input  logic [11:0] tom_y,
  input  logic [11:0] jerry_x,
  input  logic [11:0] jerry_y,
  input  logic        cheese_hit,
  output logic [1:0]  gameover,
  output logic        reset,
  output logic        playing,
  output logic [7:0]  time_left
);
  localparam int SW = $clog2(FRAMES_PER_SEC + 1);
  localparam int HW = $clog2(HIT_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, PLAY, DONE, CLEAR} state_t;
  state_t state, state_n;
  logic start_q, start_rise, collide, wrap, caught, expired, cheese_win;
  logic [SW-1:0] sec_cnt, sec_n;
  logic [HW-1:0] hit_cnt, hit_n, hit_inc;
  logic [7:0] time_n;
  logic [1:0] go_n;
  logic [11:0] dx, dy;
  assign start_rise = start & ~start_q;
  assign playing = state == PLAY;
  assign reset = state == CLEAR;
`ifdef GAMEOVER_CHEESE_EN
  logic [3:0] cheese_cnt;
  assign cheese_win = cheese_hit && cheese_cnt == 4'd9;
  always_ff @(posedge clk)
    cheese_cnt <= rst || state == CLEAR ? 4'd0 : state == PLAY ? cheese_cnt + 4'(cheese_hit) : cheese_cnt;
`else
  logic unused_cheese;
  assign unused_cheese = cheese_hit;
  assign cheese_win = 1'b0;
`endif
  always_comb begin
    dx = tom_x >= jerry_x ? tom_x - jerry_x : jerry_x - tom_x;
    dy = tom_y >= jerry_y ? tom_y - jerry_y : jerry_y - tom_y;
    collide = dx < 12'(HIT_DIST) && dy < 12'(HIT_DIST);
    hit_inc = !collide ? '0 : hit_cnt == HW'(HIT_FRAMES) ? hit_cnt : hit_cnt + 1'b1;
    wrap = sec_cnt == SW'(FRAMES_PER_SEC - 1);
    caught = frame_tick && hit_inc == HW'(HIT_FRAMES);
    expired = frame_tick && wrap && time_left == 8'd1;
    state_n = state;
    sec_n = sec_cnt;
    hit_n = hit_cnt;
    time_n = time_left;
    go_n = gameover;
    case (state)
      IDLE: state_n = start_rise ? PLAY : IDLE;
      PLAY: begin
        if (frame_tick) begin
          sec_n = wrap ? '0 : sec_cnt + 1'b1;
          hit_n = hit_inc;
          time_n = wrap ? time_left - 8'd1 : time_left;
        end
        // catch outranks cheese, cheese outranks timer expiry
        if (caught || cheese_win || expired) begin
          state_n = DONE;
          go_n = caught ? 2'b01 : cheese_win ? 2'b11 : 2'b10;
        end
      end
      DONE: if (start_rise) begin
        state_n = CLEAR;
        go_n = 2'b00;
      end
      default: begin
        state_n = IDLE;
        sec_n = '0;
        hit_n = '0;
        time_n = 8'(GAME_SECONDS);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      sec_cnt <= '0;
      hit_cnt <= '0;
      time_left <= 8'(GAME_SECONDS);
      gameover <= 2'b00;
    end else begin
      state <= state_n;
      start_q <= start;
      sec_cnt <= sec_n;
      hit_cnt <= hit_n;
      time_left <= time_n;
      gameover <= go_n;
    end
  end
endmodule

// File: tb/tb_gameover_detect.sv
// tb_gameover_detect: directed table, cheese sequence and random stimulus against a frame-count reference model
module tb_gameover_detect;
  localparam int GS = 2, FPS = 4, HD = 16, HF = 3;
  logic clk = 0, rst = 1, frame_tick = 0, start = 0, cheese_hit = 0;
  logic [11:0] tom_x = 0, tom_y = 0, jerry_x = 0, jerry_y = 0;
  logic [1:0] gameover;
  logic reset, playing;
  logic [7:0] time_left;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_frames = 0, m_run = 0, m_cheese = 0, m_go = 0;
  bit m_sq = 0;
  typedef struct {bit r, ft, st, c, ch; int go, pl, rs, tl;} vec_t;
  vec_t tbl[$];

  gameover_detect #(.GAME_SECONDS(GS), .FRAMES_PER_SEC(FPS), .HIT_DIST(HD), .HIT_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .tom_x(tom_x), .tom_y(tom_y), .jerry_x(jerry_x), .jerry_y(jerry_y),
    .cheese_hit(cheese_hit), .gameover(gameover), .reset(reset),
    .playing(playing), .time_left(time_left)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int absd(int a, int b);
    return a >= b ? a - b : b - a;
  endfunction

  // Game modes: 0 idle, 1 play, 2 ended, 3 restart pulse; time is derived from frames played
  task automatic model_step();
    bit rise = start && !m_sq;
    bit caught = 0, cw = 0, expd = 0;
    m_sq = start;
    if (rst) begin
      m_mode = 0; m_frames = 0; m_run = 0; m_cheese = 0; m_go = 0; m_sq = 0;
      return;
    end
    case (m_mode)
      0: if (rise) m_mode = 1;
      1: begin
        if (frame_tick) begin
          m_frames++;
          m_run = (absd(tom_x, jerry_x) < HD && absd(tom_y, jerry_y) < HD) ? m_run + 1 : 0;
          caught = m_run >= HF;
          expd = m_frames == GS * FPS;
        end
`ifdef GAMEOVER_CHEESE_EN
        if (cheese_hit) m_cheese++;
        cw = m_cheese == 10;
`endif
        if (caught || cw || expd) begin
          m_mode = 2;
          m_go = caught ? 1 : cw ? 3 : 2;
        end
      end
      2: if (rise) begin m_mode = 3; m_go = 0; end
      default: begin m_mode = 0; m_frames = 0; m_run = 0; m_cheese = 0; end
    endcase
  endtask

  task automatic drive(bit r, bit ft, bit st, bit ch, logic [11:0] tx, logic [11:0] ty, logic [11:0] jx, logic [11:0] jy);
    @(negedge clk);
    rst = r; frame_tick = ft; start = st; cheese_hit = ch;
    tom_x = tx; tom_y = ty; jerry_x = jx; jerry_y = jy;
    @(posedge clk);
    #1;
    model_step();
    chk("model_gameover", gameover, m_go);
    chk("model_playing", playing, m_mode == 1);
    chk("model_reset", reset, m_mode == 3);
    chk("model_time_left", time_left, m_mode == 3 ? time_left_frozen() : GS - m_frames / FPS);
  endtask

  // During the restart pulse the timer still shows its frozen value; the model's frames reset only on leaving it
  function automatic int time_left_frozen();
    return GS - m_frames / FPS;
  endfunction

  task automatic cyc(bit r, bit ft, bit st, bit c, bit ch);
    drive(r, ft, st, ch, 12'd100, 12'd100, c ? 12'd110 : 12'd200, c ? 12'd105 : 12'd100);
  endtask

  function automatic void row(bit r, bit ft, bit st, bit c, bit ch, int go, int pl, int rs, int tl);
    vec_t v;
    v.r = r; v.ft = ft; v.st = st; v.c = c; v.ch = ch; v.go = go; v.pl = pl; v.rs = rs; v.tl = tl;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset, catch after 2+1+2+1 colliding pattern, restart
    row(1,0,0,0,0, 0,0,0,2); row(0,0,1,0,0, 0,1,0,2);
    row(0,1,0,1,0, 0,1,0,2); row(0,1,0,1,0, 0,1,0,2); row(0,1,0,0,0, 0,1,0,2);
    row(0,1,0,1,0, 0,1,0,1); row(0,1,0,1,0, 0,1,0,1); row(0,0,0,1,0, 0,1,0,1);
    row(0,1,0,1,0, 1,0,0,1); row(0,1,0,1,0, 1,0,0,1);
    row(0,0,1,0,0, 0,0,1,1); row(0,0,1,0,0, 0,0,0,2); row(0,0,0,0,0, 0,0,0,2);
    // timer expiry, start held across the end
    row(0,0,1,0,0, 0,1,0,2);
    row(0,1,0,0,0, 0,1,0,2); row(0,1,0,0,0, 0,1,0,2); row(0,1,0,0,0, 0,1,0,2);
    row(0,1,0,0,0, 0,1,0,1); row(0,1,0,0,0, 0,1,0,1); row(0,1,0,0,0, 0,1,0,1);
    row(0,1,1,0,0, 0,1,0,1); row(0,1,1,0,0, 2,0,0,0); row(0,0,1,0,0, 2,0,0,0);
    row(0,0,0,0,0, 2,0,0,0); row(0,0,1,0,0, 0,0,1,0); row(0,0,0,0,0, 0,0,0,2);
    // rst mid-play
    row(0,0,1,0,0, 0,1,0,2); row(0,1,0,1,0, 0,1,0,2); row(1,1,0,1,0, 0,0,0,2);
    row(0,1,0,1,0, 0,0,0,2);
    // catch and expiry on the same tick
    row(0,0,1,0,0, 0,1,0,2);
    row(0,1,0,0,0, 0,1,0,2); row(0,1,0,0,0, 0,1,0,2); row(0,1,0,0,0, 0,1,0,2);
    row(0,1,0,0,0, 0,1,0,1); row(0,1,0,0,0, 0,1,0,1);
    row(0,1,0,1,0, 0,1,0,1); row(0,1,0,1,0, 0,1,0,1); row(0,1,0,1,0, 1,0,0,0);
    row(0,0,0,0,0, 1,0,0,0); row(0,0,1,0,0, 0,0,1,0); row(0,0,0,0,0, 0,0,0,2);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].ft, tbl[i].st, tbl[i].c, tbl[i].ch);
      chk($sformatf("tbl%0d_gameover", i), gameover, tbl[i].go);
      chk($sformatf("tbl%0d_playing", i), playing, tbl[i].pl);
      chk($sformatf("tbl%0d_reset", i), reset, tbl[i].rs);
      chk($sformatf("tbl%0d_time_left", i), time_left, tbl[i].tl);
    end
    // ten cheese pulses in play
    cyc(0,0,1,0,0);
    for (int i = 0; i < 10; i++) cyc(0,0,0,0,1);
`ifdef GAMEOVER_CHEESE_EN
    chk("cheese_gameover", gameover, 3);
    chk("cheese_playing", playing, 0);
`else
    chk("cheese_gameover", gameover, 0);
    chk("cheese_playing", playing, 1);
`endif
    cyc(1,0,0,0,0);
    chk("cheese_rst_gameover", gameover, 0);
    for (int i = 0; i < 4000; i++) begin
      bit wide = $urandom_range(0, 9) == 0;
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0 ? !start : start, $urandom_range(0, 2) == 0,
            wide ? 12'($urandom) : 12'(100 + $urandom_range(0, 40)),
            12'(100 + $urandom_range(0, 40)),
            wide ? 12'($urandom) : 12'(100 + $urandom_range(0, 40)),
            12'(100 + $urandom_range(0, 40)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
